// File: rtl/c17_pkg.sv
// Shared constants and helpers for the C17 V3 lane array.
// Gate indices follow the original netlist instance numbering.
package c17_pkg;

   localparam int C17_IN_W  = 5;
   localparam int C17_OUT_W = 2;
   localparam int C17_GATES = 6;

   localparam int U0 = 0;
   localparam int U1 = 1;
   localparam int U2 = 2;
   localparam int U3 = 3;
   localparam int U4 = 4;
   localparam int U5 = 5;

   function automatic logic [C17_OUT_W-1:0] maj3(input logic [C17_OUT_W-1:0] a,
                                                 input logic [C17_OUT_W-1:0] b,
                                                 input logic [C17_OUT_W-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/c17_v3_core.sv
// One combinational C17 V3 copy; every gate output can be flipped by its mask bit.
module c17_v3_core
   import c17_pkg::*;
(
   input  logic [C17_IN_W-1:0]  in_g,
   input  logic [C17_GATES-1:0] mask,
   output logic [C17_OUT_W-1:0] out_g
);

   logic g1, g2, g3, g4, g5;
   logic w1, w2, w3, w4, g6, g7;

   assign {g5, g4, g3, g2, g1} = in_g;

   // A flipped w1 deliberately feeds both w3 and w4.
   assign w1 = ~(g5 & g2) ^ mask[U0];
   assign w2 = ~(g5 & g1) ^ mask[U2];
   assign w3 = ~(w1 & g4) ^ mask[U1];
   assign w4 = ~(w1 & g3) ^ mask[U4];
   assign g6 = ~(w2 & w3) ^ mask[U3];
   assign g7 = ~(w4 & w3) ^ mask[U5];

   assign out_g = {g7, g6};

endmodule

// File: rtl/c17_tmr_array.sv
// LANES parallel C17 V3 lanes, optionally triplicated with majority voting,
// behind a two-stage valid/ready pipeline with a saturating mismatch counter.
module c17_tmr_array
   import c17_pkg::*;
#(
   parameter int LANES = 4,
   parameter int TMR   = 1,
   parameter int CNT_W = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [C17_IN_W*LANES-1:0]      in_g,
   input  logic [3*C17_GATES*LANES-1:0]   fi_mask,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [C17_OUT_W*LANES-1:0]     out_g,
   output logic [LANES-1:0]               out_err,
   output logic [CNT_W-1:0]               err_count,
   input  logic                           clr_count
);

   localparam int NCOPY       = (TMR != 0) ? 3 : 1;
   localparam int LANE_MASK_W = 3 * C17_GATES;

   logic                             s1_en, s2_en;
   logic                             vld_p1, vld_p2;
   logic [C17_IN_W*LANES-1:0]        g_p1;
   logic [LANE_MASK_W*LANES-1:0]     mask_p1;
   logic [C17_OUT_W*LANES-1:0]       g_nxt, g_p2;
   logic [LANES-1:0]                 err_nxt, err_p2;
   logic [CNT_W-1:0]                 cnt_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign s2_en    = ~vld_p2 | out_ready;
   assign s1_en    = ~vld_p1 | s2_en;
   assign in_ready = s1_en;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [C17_OUT_W-1:0] cp [NCOPY];

      for (genvar c = 0; c < NCOPY; c++) begin : g_copy
         c17_v3_core u_core (
            .in_g  (g_p1[C17_IN_W*i +: C17_IN_W]),
            .mask  (mask_p1[LANE_MASK_W*i + C17_GATES*c +: C17_GATES]),
            .out_g (cp[c])
         );
      end

      if (TMR != 0) begin : g_vote
         assign g_nxt[C17_OUT_W*i +: C17_OUT_W] = maj3(cp[0], cp[1], cp[2]);
         assign err_nxt[i] = (cp[0] != cp[1]) || (cp[1] != cp[2]);
      end else begin : g_pass
         // Copy 1/2 masks have no effect on a single-copy build.
         logic mask_unused;
         assign mask_unused = ^mask_p1[LANE_MASK_W*i + C17_GATES +: 2*C17_GATES];
         assign g_nxt[C17_OUT_W*i +: C17_OUT_W] = cp[0];
         assign err_nxt[i] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (s1_en) vld_p1 <= in_valid;
         if (s2_en) vld_p2 <= vld_p1;
      end
   end

   // S1: capture the input vector and its fault masks on transfer
   always_ff @(posedge clk) begin
      if (s1_en && in_valid) begin
         g_p1    <= in_g;
         mask_p1 <= fi_mask;
      end
   end

   // S2: voted result, cleared on reset so nothing stale shows afterwards
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_p2   <= '0;
         err_p2 <= '0;
      end else if (s2_en && vld_p1) begin
         g_p2   <= g_nxt;
         err_p2 <= err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr_count) begin
         cnt_q <= '0;
      end else if (s2_en && vld_p1 && (|err_nxt)) begin
         cnt_q <= sat_inc(cnt_q);
      end
   end

   assign out_valid = vld_p2;
   assign out_g     = g_p2;
   assign out_err   = err_p2;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_c17_tmr_array.sv
// Bench for c17_tmr_array: three builds (TMR, TMR with 2-bit counter, single copy)
// checked every cycle against a transaction-queue model plus directed literals.
module tb_c17_tmr_array;

   localparam int L = 4;

   typedef struct {
      logic [7:0] g;
      logic [3:0] err;
      int         acc;
   } item_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        in_valid  [3];
   logic [19:0] in_g      [3];
   logic [71:0] fi_mask   [3];
   logic        out_ready [3];
   logic        clr_count [3];
   logic        in_ready  [3];
   logic        out_valid [3];
   logic [7:0]  out_g     [3];
   logic [3:0]  out_err   [3];
   logic [15:0] cnt0, cnt2;
   logic [1:0]  cnt1;

   c17_tmr_array #(.LANES(4), .TMR(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_g(in_g[0]), .fi_mask(fi_mask[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_g(out_g[0]), .out_err(out_err[0]),
      .err_count(cnt0), .clr_count(clr_count[0]));

   c17_tmr_array #(.LANES(4), .TMR(1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_g(in_g[1]), .fi_mask(fi_mask[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_g(out_g[1]), .out_err(out_err[1]),
      .err_count(cnt1), .clr_count(clr_count[1]));

   c17_tmr_array #(.LANES(4), .TMR(0), .CNT_W(16)) dut_ntmr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_g(in_g[2]), .fi_mask(fi_mask[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .out_g(out_g[2]), .out_err(out_err[2]),
      .err_count(cnt2), .clr_count(clr_count[2]));

   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   bit    chk_en  = 0;
   item_t mq   [3][256];
   int    head [3];
   int    tail [3];
   int    mcnt [3];

   function automatic logic [15:0] dut_cnt(input int k);
      if (k == 0) return cnt0;
      if (k == 1) return {14'd0, cnt1};
      return cnt2;
   endfunction

   function automatic int cmax(input int k);
      return (k == 1) ? 3 : 65535;
   endfunction

   // Reference C17 V3 copy: mask bit order U0..U5 = w1,w3,w2,G6,w4,G7.
   function automatic logic [1:0] c17(input logic [4:0] g, input logic [5:0] m);
      logic g1, g2, g3, g4, g5, w1, w2, w3, w4, g6, g7;
      {g5, g4, g3, g2, g1} = g;
      w1 = ~(g5 & g2) ^ m[0];
      w2 = ~(g5 & g1) ^ m[2];
      w3 = ~(w1 & g4) ^ m[1];
      w4 = ~(w1 & g3) ^ m[4];
      g6 = ~(w2 & w3) ^ m[3];
      g7 = ~(w4 & w3) ^ m[5];
      return {g7, g6};
   endfunction

   function automatic item_t mk(input int k, input logic [19:0] g, input logic [71:0] m);
      item_t      it;
      logic [1:0] c [3];
      int         votes;
      it.g = '0; it.err = '0; it.acc = 0;
      for (int i = 0; i < L; i++) begin
         for (int j = 0; j < 3; j++) c[j] = c17(g[5*i +: 5], m[18*i + 6*j +: 6]);
         if (k == 2) begin
            it.g[2*i +: 2] = c[0];
         end else begin
            for (int b = 0; b < 2; b++) begin
               votes = int'(c[0][b]) + int'(c[1][b]) + int'(c[2][b]);
               it.g[2*i + b] = (votes >= 2);
            end
            it.err[i] = !((c[0] == c[1]) && (c[1] == c[2]));
         end
      end
      return it;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: a FIFO of accepted transactions; the head is visible one edge after acceptance.
   always @(posedge clk) begin
      int  size, s1i;
      bit  hvis, s1ex, mv;
      item_t it;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            head[k] = tail[k];
            mcnt[k] = 0;
         end else begin
            size = tail[k] - head[k];
            hvis = (size > 0) && (cyc > mq[k][head[k]].acc + 1);
            s1i  = hvis ? head[k] + 1 : head[k];
            s1ex = (s1i < tail[k]);
            mv   = s1ex && (!hvis || out_ready[k]);
            if (clr_count[k]) mcnt[k] = 0;
            else if (mv && (|mq[k][s1i].err) && mcnt[k] < cmax(k)) mcnt[k]++;
            if (hvis && out_ready[k]) head[k]++;
            if (in_valid[k] && (size < 2 || out_ready[k]) && tail[k] < 256) begin
               it = mk(k, in_g[k], fi_mask[k]);
               it.acc = cyc;
               mq[k][tail[k]] = it;
               tail[k]++;
            end
         end
      end
      if (!rst_n) chk_en = 1;
      cyc++;
   end

   initial begin
      int size;
      bit vis;
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
               size = tail[k] - head[k];
               vis  = (size > 0) && (cyc > mq[k][head[k]].acc + 1);
               chk($sformatf("in_ready[%0d]", k), in_ready[k], (size < 2) || out_ready[k]);
               chk($sformatf("out_valid[%0d]", k), out_valid[k], vis);
               if (vis) begin
                  chk($sformatf("out_g[%0d]", k), out_g[k], mq[k][head[k]].g);
                  chk($sformatf("out_err[%0d]", k), out_err[k], mq[k][head[k]].err);
               end
               chk($sformatf("err_count[%0d]", k), dut_cnt(k), mcnt[k]);
            end
         end
      end
   end

   task automatic send(input int k, input logic [19:0] g, input logic [71:0] m);
      logic r;
      bit   ok;
      ok = 0;
      @(negedge clk);
      in_valid[k] = 1'b1; in_g[k] = g; fi_mask[k] = m;
      for (int t = 0; t < 40 && !ok; t++) begin
         #1 r = in_ready[k];
         @(posedge clk);
         if (r) ok = 1;
         else @(negedge clk);
      end
      chk("send_accepted", ok, 1);
      #1 in_valid[k] = 1'b0;
   endtask

   task automatic wait_out(input int k, output logic [7:0] g, output logic [3:0] e,
                           output logic [15:0] c, output int n);
      bit ok;
      ok = 0; g = '0; e = '0; c = '0; n = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         #1 n++;
         if (out_valid[k]) begin
            ok = 1; g = out_g[k]; e = out_err[k]; c = dut_cnt(k);
         end
      end
      chk("wait_out", ok, 1);
   endtask

   initial begin
      logic [7:0]  g;
      logic [3:0]  e;
      logic [15:0] c;
      int          n, idx, stall_seen;
      logic        r;
      logic [3:0]  pat;
      logic [19:0] vs [8];
      logic [71:0] ms [8];
      logic [71:0] m;
      item_t       it;

      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; in_g[k] = '0; fi_mask[k] = '0;
         out_ready[k] = 1'b1; clr_count[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      for (int k = 0; k < 3; k++) begin
         chk("rst_out_valid", out_valid[k], 0);
         chk("rst_in_ready", in_ready[k], 1);
         chk("rst_out_g", out_g[k], 0);
         chk("rst_out_err", out_err[k], 0);
         chk("rst_err_count", dut_cnt(k), 0);
      end

      chk("model_00000", c17(5'b00000, 6'd0), 2'b00);
      chk("model_11111", c17(5'b11111, 6'd0), 2'b01);
      chk("model_11100", c17(5'b11100, 6'd0), 2'b11);
      chk("model_u0", c17(5'b11100, 6'b000001), 2'b00);
      chk("model_u1", c17(5'b11100, 6'b000010), 2'b10);
      it = mk(0, {4{5'b11100}}, 72'h40);
      chk("model_vote_g", it.g, 8'hFF);
      chk("model_vote_err", it.err, 4'b0001);

      send(0, {4{5'b00000}}, '0);
      wait_out(0, g, e, c, n);
      chk("g_00000", g, 8'h00);
      chk("latency", n, 2);
      chk("err_00000", e, 0);
      send(0, {4{5'b11111}}, '0);
      wait_out(0, g, e, c, n);
      chk("g_11111", g, 8'h55);
      send(0, {4{5'b11100}}, '0);
      wait_out(0, g, e, c, n);
      chk("g_11100", g, 8'hFF);
      chk("cnt_clean", c, 0);
      send(0, {4{5'b11100}}, 72'h40);
      wait_out(0, g, e, c, n);
      chk("g_c1_fault", g, 8'hFF);
      chk("err_c1_fault", e, 4'b0001);
      chk("cnt_c1_fault", c, 1);
      send(0, {4{5'b11100}}, 72'h1040);
      wait_out(0, g, e, c, n);
      chk("g_c12_fault", g, 8'hFC);
      chk("err_c12_fault", e, 4'b0001);
      chk("cnt_c12_fault", c, 2);

      pat = 4'b1001;
      for (int i = 0; i < 8; i++) begin
         vs[i] = 20'(32'h5A3C1 * (i + 3));
         ms[i] = (i % 3 == 0) ? (72'h1 << (6 + 18 * (i % 4))) : 72'h0;
      end
      idx = 0; stall_seen = 0;
      for (int t = 0; t < 200 && idx < 8; t++) begin
         @(negedge clk);
         out_ready[0] = pat[t % 4];
         in_valid[0] = 1'b1; in_g[0] = vs[idx]; fi_mask[0] = ms[idx];
         #1 r = in_ready[0];
         if (!r) stall_seen++;
         @(posedge clk);
         if (r) idx++;
      end
      @(negedge clk);
      in_valid[0] = 1'b0; out_ready[0] = 1'b1;
      repeat (4) @(posedge clk);
      chk("stream_sent", idx, 8);
      chk("stream_stalled", stall_seen > 0, 1);
      chk("stream_drained", tail[0] - head[0], 0);

      for (int i = 0; i < 5; i++) send(1, {4{5'b11100}}, 72'h40);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 chk("sat_hold", cnt1, 3);
      send(1, {4{5'b11100}}, 72'h40);
      @(negedge clk);
      clr_count[1] = 1'b1;
      @(posedge clk);
      #1 clr_count[1] = 1'b0;
      @(negedge clk);
      #1 chk("clr_priority", cnt1, 0);

      @(negedge clk);
      out_ready[0] = 1'b0;
      send(0, {4{5'b11111}}, '0);
      send(0, {4{5'b11100}}, 72'h40);
      @(negedge clk);
      #1 chk("full_in_ready", in_ready[0], 0);
      chk("full_out_valid", out_valid[0], 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1 chk("midrst_out_valid", out_valid[0], 0);
      chk("midrst_cnt", cnt0, 0);
      chk("midrst_in_ready", in_ready[0], 1);
      out_ready[0] = 1'b1;
      repeat (3) @(posedge clk);
      chk("midrst_no_output", tail[0] - head[0], 0);

      m = '0;
      for (int i = 0; i < L; i++) m = m | (72'h1040 << (18 * i));
      send(2, {4{5'b11100}}, m);
      wait_out(2, g, e, c, n);
      chk("ntmr_g", g, 8'hFF);
      chk("ntmr_err", e, 0);
      chk("ntmr_cnt", c, 0);
      for (int i = 0; i < L; i++) m = m | (72'h1 << (18 * i));
      send(2, {4{5'b11100}}, m);
      wait_out(2, g, e, c, n);
      chk("ntmr_c0_g", g, 8'h00);
      chk("ntmr_c0_err", e, 0);
      chk("ntmr_c0_cnt", c, 0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
